instruction_memory: RTL and testbench

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/instruction_memory_pkg.sv | 27 ++
 rtl/instruction_memory.sv | 39 +++
 tb/tb_instruction_memory.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction ROM: default geometry, the NOP word and
// the fixed program image loaded into the low words of the ROM.
package instruction_memory_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DEPTH      = 256;

  typedef logic [15:0] instr_t;

  localparam instr_t      NOP             = 16'h0000;
  localparam int unsigned ROM_IMAGE_WORDS = 8;

  localparam instr_t ROM_IMAGE [ROM_IMAGE_WORDS] = '{
    16'h3042, 16'h5101, 16'h2252, 16'h6003,
    16'h7104, 16'h8A05, 16'hC000, 16'hF000
  };

  // Words beyond the program image read as NOP.
  function automatic instr_t rom_image_word(input int unsigned idx);
    instr_t word;
    word = NOP;
    if (idx < ROM_IMAGE_WORDS) word = ROM_IMAGE[idx[2:0]];
    return word;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed read-only instruction store with a registered output.
// Addresses at or beyond DEPTH fetch NOP; reset clears the output register.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] AddressBus,
  output logic [DATA_WIDTH-1:0] InstructionReg
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] rom [DEPTH];
  logic [DATA_WIDTH-1:0] instr_d;
  logic [DATA_WIDTH-1:0] instr_q = '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = DATA_WIDTH'(rom_image_word(g));
  end

  // Range check is done at 32 bits so out-of-range addresses never alias.
  always_comb begin
    instr_d = DATA_WIDTH'(NOP);
    if (32'(AddressBus) < 32'(DEPTH)) instr_d = rom[AddressBus[IDX_W-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) instr_q <= '0;
    else       instr_q <= instr_d;
  end

  assign InstructionReg = instr_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: expected words are queued as each
// address is driven and compared one cycle later, just after the rising edge.
`timescale 1ns/1ps

module clock_generator (
  output logic clock
);
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
endmodule

module tb_instruction_memory;

  logic        clock;
  logic        reset;
  logic [15:0] AddressBus;
  logic [15:0] InstructionReg;

  logic [15:0] exp_q [$];
  logic [15:0] exp_word;
  logic [15:0] held_word;
  int          total;
  int          bad;

  clock_generator u_clk (.clock(clock));

  instruction_memory #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .DEPTH     (256)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .AddressBus    (AddressBus),
    .InstructionReg(InstructionReg)
  );

  function automatic logic [15:0] model_rom(input logic [15:0] addr);
    case (addr)
      16'd0:   return 16'h3042;
      16'd1:   return 16'h5101;
      16'd2:   return 16'h2252;
      16'd3:   return 16'h6003;
      16'd4:   return 16'h7104;
      16'd5:   return 16'h8A05;
      16'd6:   return 16'hC000;
      16'd7:   return 16'hF000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_power_up();
    #1;
    total++;
    if (InstructionReg !== 16'h0000) begin
      bad++;
      $display("FAIL power_up: got %h want 0000", InstructionReg);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    AddressBus = 16'd1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'h0000);
      next_edge();
      total++;
      exp_word = exp_q.pop_front();
      if (InstructionReg !== exp_word) begin
        bad++;
        $display("FAIL reset_%0d: got %h want %h", i, InstructionReg, exp_word);
      end
    end
  endtask

  task automatic test_base_read();
    reset      = 1'b0;
    AddressBus = 16'd0;
    exp_q.push_back(16'h3042);
    next_edge();
    total++;
    exp_word = exp_q.pop_front();
    if (InstructionReg !== exp_word) begin
      bad++;
      $display("FAIL base_read: got %h want %h", InstructionReg, exp_word);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] want [3];
    want = '{16'h5101, 16'h2252, 16'h6003};
    for (int i = 0; i < 3; i++) begin
      AddressBus = 16'(i + 1);
      exp_q.push_back(want[i]);
      next_edge();
      total++;
      exp_word = exp_q.pop_front();
      if (InstructionReg !== exp_word) begin
        bad++;
        $display("FAIL seq_addr%0d: got %h want %h", i + 1, InstructionReg, exp_word);
      end
    end
  endtask

  task automatic test_mid_cycle();
    held_word  = 16'h6003;
    AddressBus = 16'd4;
    #2;
    AddressBus = 16'd5;
    exp_q.push_back(16'h8A05);
    #1;
    total++;
    if (InstructionReg !== held_word) begin
      bad++;
      $display("FAIL mid_cycle_hold: got %h want %h", InstructionReg, held_word);
    end
    next_edge();
    total++;
    exp_word = exp_q.pop_front();
    if (InstructionReg !== exp_word) begin
      bad++;
      $display("FAIL mid_cycle_load: got %h want %h", InstructionReg, exp_word);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] addrs [2];
    addrs = '{16'h0100, 16'hFFFF};
    for (int i = 0; i < 2; i++) begin
      AddressBus = addrs[i];
      exp_q.push_back(16'h0000);
      next_edge();
      total++;
      exp_word = exp_q.pop_front();
      if (InstructionReg !== exp_word) begin
        bad++;
        $display("FAIL oor_%h: got %h want %h", addrs[i], InstructionReg, exp_word);
      end
    end
  endtask

  task automatic test_mid_run_reset();
    AddressBus = 16'd6;
    next_edge();
    reset      = 1'b1;
    AddressBus = 16'd7;
    exp_q.push_back(16'h0000);
    next_edge();
    total++;
    exp_word = exp_q.pop_front();
    if (InstructionReg !== exp_word) begin
      bad++;
      $display("FAIL midrun_reset: got %h want %h", InstructionReg, exp_word);
    end
    reset = 1'b0;
    exp_q.push_back(16'hF000);
    next_edge();
    total++;
    exp_word = exp_q.pop_front();
    if (InstructionReg !== exp_word) begin
      bad++;
      $display("FAIL midrun_release: got %h want %h", InstructionReg, exp_word);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [16];
    addrs = '{16'd7, 16'd8, 16'd255, 16'd256, 16'd0, 16'd3, 16'd6, 16'd5,
              16'h8000, 16'd2, 16'd1, 16'd4, 16'd9, 16'd128, 16'hFF07, 16'd7};
    for (int i = 0; i < 16; i++) begin
      AddressBus = addrs[i];
      exp_q.push_back(model_rom(addrs[i]));
      next_edge();
      total++;
      exp_word = exp_q.pop_front();
      if (InstructionReg !== exp_word) begin
        bad++;
        $display("FAIL b2b_%h: got %h want %h", addrs[i], InstructionReg, exp_word);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    AddressBus = 16'd1;
    test_power_up();
    test_reset();
    test_base_read();
    test_sequential();
    test_mid_cycle();
    test_out_of_range();
    test_mid_run_reset();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
